demux_1_to_2_reg: RTL
=====================

// Module: demux_1_to_2_reg
// PURPOSE
//   Registered 1-to-2 demultiplexer with valid/ready flow control; the inverse of the 32-bit 2:1 mux.
//   Routes one 32-bit input word to output port A (select=0) or port B (select=1).
//   Each port has a one-entry holding register and a delivered-word counter.
//   Sits between the ALU/load result path and two downstream consumers (register-file write port, store buffer).
// PARAMETERS
//   DATA_W   32   width of data word
//   CNT_W    16   width of per-port delivered-word counters (saturating)
// PORTS
//   clk          input   1        rising-edge clock
//   rst          input   1        asynchronous, active-high reset
//   in_data      input   DATA_W   word to route
//   in_select    input   1        0 -> port A, 1 -> port B; sampled with in_data
//   in_valid     input   1        in_data/in_select valid this cycle
//   in_ready     output  1        block accepts the word this cycle (combinational)
//   a_data       output  DATA_W   port A held word
//   a_valid      output  1        port A holds an undelivered word
//   a_ready      input   1        port A consumer takes word this cycle
//   b_data       output  DATA_W   port B held word
//   b_valid      output  1        port B holds an undelivered word
//   b_ready      input   1        port B consumer takes word this cycle
//   a_count      output  CNT_W    words delivered on A (a_valid & a_ready), saturates at all-ones
//   b_count      output  CNT_W    words delivered on B, saturates at all-ones
// BEHAVIOUR
//   - Reset (async, any time): a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0; in-flight words dropped.
//   - Accept = in_valid & in_ready. in_ready = ~sel_valid | sel_ready, where sel_* is the port named by in_select.
//     in_ready depends only on in_select and the selected port; the other port never stalls the input.
//   - Latency: a word accepted at edge N appears on the selected port with valid=1 after edge N (1 cycle).
//   - Hold rule: while x_valid=1 and x_ready=0, x_data is stable and x_valid stays 1.
//   - Per-port register next state:
//       load (accept for this port)        -> x_data<=in_data, x_valid<=1
//       drain only (x_valid & x_ready)     -> x_valid<=0, x_data unchanged
//       load and drain same cycle          -> x_data<=in_data, x_valid stays 1 (full throughput)
//       neither                            -> hold
//   - The unselected port drains independently in the same cycle as a load of the other port.
//   - in_valid=0: no load; in_select/in_data ignored.
//   - Counters: x_count += 1 on each x_valid & x_ready edge; at 2^CNT_W-1 the counter holds (no wrap).
//   - No combinational path from in_* to a_*/b_* outputs; the only combinational path is x_ready/in_select -> in_ready.
// STRUCTURE
//   - Shared package (demux_pkg): DATA_W/CNT_W defaults and localparams SEL_A=1'b0, SEL_B=1'b1.
//   - Sub-module demux_port_reg: one-entry holding register plus saturating counter, with ports
//     clk, rst, load, load_data, ready -> data, valid, count, can_load. Instantiated twice (A, B).
//   - Top level: load decode from in_select/in_valid, plus an in_ready mux of the two can_load outputs.
// TESTING
//   1. Assert rst mid-run with a_valid=1 -> a_valid=b_valid=0, a/b_data=0, counts=0 immediately, before the next clk edge.
//   2. in_data=15, sel=0, valid=1, a_ready=1 -> next cycle a_data=15, a_valid=1, b_valid=0;
//      the following edge gives a_count=1.
//   3. in_data=10, sel=1, b_ready=0 for 3 cycles -> b_data=10, b_valid=1 held;
//      a second sel=1 word sees in_ready=0 and is not accepted until b_ready=1.
//   4. Port B full and stalled, sel=0 word 7 offered -> in_ready=1, a_data=7 next cycle; B unchanged.
//   5. Back-to-back sel=0 words 1,2,3 with a_ready=1 throughout -> in_ready stays 1;
//      a_data is 1,2,3 on consecutive cycles and a_count=3.
//   6. Force a_count to 16'hFFFE, deliver 3 words -> a_count=16'hFFFF and holds.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer: widths, port selects
// and the per-port register operation decode.
package demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int NUM_PORTS  = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // What a holding register does on the next edge; encoded as {load, drain}.
  typedef enum logic [1:0] {
    PORT_HOLD  = 2'b00,
    PORT_DRAIN = 2'b01,
    PORT_LOAD  = 2'b10,
    PORT_PASS  = 2'b11
  } port_op_e;

  function automatic port_op_e port_op(input logic load, input logic drain);
    port_op_e op;
    case ({load, drain})
      2'b01:   op = PORT_DRAIN;
      2'b10:   op = PORT_LOAD;
      2'b11:   op = PORT_PASS;
      default: op = PORT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/demux_port_reg.sv
// One output port of the demux: a one-entry holding register with valid/ready
// handshake and a saturating count of delivered words.
module demux_port_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              can_load
);

  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              drain;
  port_op_e          op;

  assign drain    = valid_reg & ready;
  assign can_load = ~valid_reg | ready;
  assign op       = port_op(load, drain);

  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    case (op)
      PORT_LOAD, PORT_PASS: begin
        data_next  = load_data;
        valid_next = 1'b1;
      end
      PORT_DRAIN: valid_next = 1'b0;
      default: ;
    endcase
  end

  // Counter sticks at all-ones instead of wrapping.
  always_comb begin
    count_next = count_reg;
    if (drain && (count_reg != {CNT_W{1'b1}}))
      count_next = count_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  assign count = count_reg;

endmodule

// File: rtl/demux_1_to_2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready flow control. The input only
// stalls on the port it addresses; outputs are purely registered.
module demux_1_to_2_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_select,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  logic                 ready_vec    [NUM_PORTS];
  logic                 load_vec     [NUM_PORTS];
  logic                 can_load_vec [NUM_PORTS];
  logic                 valid_vec    [NUM_PORTS];
  logic [DATA_W-1:0]    data_arr     [NUM_PORTS];
  logic [CNT_W-1:0]     count_arr    [NUM_PORTS];

  assign ready_vec[0] = a_ready;
  assign ready_vec[1] = b_ready;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      localparam logic PORT_SEL = (gi == 0) ? SEL_A : SEL_B;

      // A port loads only when the word is addressed to it and it can take it.
      assign load_vec[gi] = in_valid & (in_select == PORT_SEL) & can_load_vec[gi];

      demux_port_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_port (
        .clk       (clk),
        .rst       (rst),
        .load      (load_vec[gi]),
        .load_data (in_data),
        .ready     (ready_vec[gi]),
        .data      (data_arr[gi]),
        .valid     (valid_vec[gi]),
        .count     (count_arr[gi]),
        .can_load  (can_load_vec[gi])
      );
    end
  endgenerate

  assign in_ready = (in_select == SEL_B) ? can_load_vec[1] : can_load_vec[0];

  assign a_data  = data_arr[0];
  assign a_valid = valid_vec[0];
  assign a_count = count_arr[0];
  assign b_data  = data_arr[1];
  assign b_valid = valid_vec[1];
  assign b_count = count_arr[1];

endmodule
